// File: rtl/uart_burst_io.sv
// uart_burst_io: multi-byte UART read/write sequencer driving a shared 32-bit data bus
module uart_burst_io #(
  parameter int BYTES    = 1,
  parameter int RD_PULSE = 1,
  parameter int WR_PULSE = 1,
  parameter int TIMEOUT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               oen,
  input  logic               wen,
  input  logic [8*BYTES-1:0] data_in,
  output logic [8*BYTES-1:0] data_out,
  output logic               done,
  output logic               err,
  inout  wire  [31:0]        base_ram_data_wire,
  output logic               uart_rdn,
  output logic               uart_wrn,
  input  logic               uart_dataready,
  input  logic               uart_tbre,
  input  logic               uart_tsre
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_STROBE, WR_SETUP, WR_STROBE, WR_TBRE, WR_TSRE, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_idx;
  logic [15:0] r_timer, r_pcnt;
  logic [8*BYTES-1:0] r_wdata, r_asm, w_asm;
  logic [7:0] w_wbyte;
  logic w_last, w_plast, w_wait, w_to, w_drive, w_unused;
  assign w_unused = ^base_ram_data_wire[31:8];
  assign w_last = r_idx == 2'(BYTES - 1);
  assign w_plast = r_pcnt == 16'd0;
  assign w_wait = (r_state == RD_WAIT && !uart_dataready) || (r_state == WR_TBRE && !uart_tbre) || (r_state == WR_TSRE && !uart_tsre);
  assign w_to = TIMEOUT != 0 && w_wait && r_timer == 16'(TIMEOUT - 1);
  always_comb begin
    w_wbyte = '0;
    w_asm = r_asm;
    for (int k = 0; k < BYTES; k++) begin
      if (r_idx == 2'(k)) begin
        w_wbyte = r_wdata[8*k +: 8];
        w_asm[8*k +: 8] = base_ram_data_wire[7:0];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = !oen ? RD_WAIT : !wen ? WR_SETUP : IDLE;
      RD_WAIT:   w_next = uart_dataready ? RD_STROBE : w_to ? DONE : RD_WAIT;
      RD_STROBE: w_next = !w_plast ? RD_STROBE : w_last ? DONE : RD_WAIT;
      WR_SETUP:  w_next = WR_STROBE;
      WR_STROBE: w_next = w_plast ? WR_TBRE : WR_STROBE;
      WR_TBRE:   w_next = uart_tbre ? WR_TSRE : w_to ? DONE : WR_TBRE;
      WR_TSRE:   w_next = uart_tsre ? (w_last ? DONE : WR_SETUP) : w_to ? DONE : WR_TSRE;
      DONE:      w_next = (oen && wen) ? IDLE : DONE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    uart_rdn = r_state != RD_STROBE;
    uart_wrn = r_state != WR_STROBE;
    done = r_state == DONE;
    w_drive = r_state inside {WR_SETUP, WR_STROBE, WR_TBRE, WR_TSRE};
  end
  assign base_ram_data_wire = w_drive ? {24'h0, w_wbyte} : 32'hz;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_timer <= '0;
      r_pcnt <= '0;
      r_wdata <= '0;
      r_asm <= '0;
      data_out <= '0;
      err <= 1'b0;
    end else begin
      r_timer <= w_wait ? r_timer + 16'd1 : '0;
      r_pcnt <= w_next != r_state ? 16'(w_next == RD_STROBE ? RD_PULSE - 1 : WR_PULSE - 1) : r_pcnt - 16'd1;
      if (r_state == IDLE && !(oen && wen)) begin
        r_idx <= '0;
        err <= 1'b0;
        if (oen) r_wdata <= data_in;
      end
      if (r_state == RD_STROBE && w_plast) begin
        r_asm <= w_asm;
        if (w_last) data_out <= w_asm;
        else r_idx <= r_idx + 2'd1;
      end
      if (r_state == WR_TSRE && uart_tsre && !w_last) r_idx <= r_idx + 2'd1;
      if (w_to) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_burst_io.sv
// tb_uart_burst_io: self-checking bench with a UART responder model and a word-level reference
module tb_uart_burst_io;
  localparam int BYTES = 4, RDP = 2, WRP = 3, TMO = 10;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic oen, wen, dready, tbre, tsre, probe, done, err, rdn, wrn;
  logic [31:0] data_in, data_out, exp_out;
  logic exp_err;
  logic [7:0] u_byte;
  wire [31:0] bus;
  logic oen1, dready1, rdn1, wrn1, done1, err1;
  logic [7:0] b1, data_out1;
  wire [31:0] bus1;
  int n_cmp = 0, n_bad = 0;
  assign bus = (!rdn || probe) ? {24'h0, rdn ? 8'h00 : u_byte} : 32'hz;
  assign bus1 = (!rdn1 || probe) ? {24'h0, rdn1 ? 8'h00 : b1} : 32'hz;
  uart_burst_io #(.BYTES(BYTES), .RD_PULSE(RDP), .WR_PULSE(WRP), .TIMEOUT(TMO)) u0 (
    .clk(clk), .rst(rst), .oen(oen), .wen(wen), .data_in(data_in), .data_out(data_out),
    .done(done), .err(err), .base_ram_data_wire(bus), .uart_rdn(rdn), .uart_wrn(wrn),
    .uart_dataready(dready), .uart_tbre(tbre), .uart_tsre(tsre));
  uart_burst_io u1 (
    .clk(clk), .rst(rst), .oen(oen1), .wen(1'b1), .data_in(8'h00), .data_out(data_out1),
    .done(done1), .err(err1), .base_ram_data_wire(bus1), .uart_rdn(rdn1), .uart_wrn(wrn1),
    .uart_dataready(dready1), .uart_tbre(1'b0), .uart_tsre(1'b0));
  typedef struct {
    logic rd;
    logic both;
    logic [31:0] w;
    int ns;
    logic [31:0] exp_out;
    logic exp_err;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask
  always @(negedge clk) if (!rst) chk("one_strobe", rdn | wrn, 1'b1);
  task automatic do_read(input logic [31:0] w, input int ns, input logic both);
    int n;
    oen = 1'b0;
    wen = both ? 1'b0 : 1'b1;
    data_in = ~w;
    @(posedge clk); #1;
    oen = 1'b1;
    wen = 1'b1;
    chk("rd_bus_hiz_wait", bus, 0);
    chk("rd_wrn_high", wrn, 1);
    for (int i = 0; i < ns; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      u_byte = w[i*8 +: 8];
      dready = 1'b1;
      n = 0;
      while (rdn && n < 20) begin n++; @(posedge clk); #1; end
      chk("rd_strobe_seen", rdn, 0);
      dready = 1'b0;
      n = 0;
      while (!rdn && n < 20) begin n++; @(posedge clk); #1; end
      chk("rd_pulse_len", n, RDP);
    end
    if (ns == BYTES) begin
      exp_out = w;
      exp_err = 1'b0;
      chk("rd_done", done, 1);
    end else begin
      n = 0;
      while (!done && n < 40) begin n++; @(posedge clk); #1; end
      chk("rd_timeout_cycles", n, TMO);
      exp_err = 1'b1;
    end
    chk("rd_data_out", data_out, exp_out);
    chk("rd_err", err, exp_err);
    chk("rd_strobes", {rdn, wrn}, 2'b11);
    chk("rd_bus_hiz", bus, 0);
    @(posedge clk); #1;
    chk("rd_idle", done, 0);
    chk("rd_err_hold", err, exp_err);
  endtask
  task automatic do_write(input logic [31:0] w);
    int n;
    logic [31:0] pb;
    data_in = w;
    wen = 1'b0;
    probe = 1'b0;
    tbre = 1'b0;
    tsre = 1'b0;
    @(posedge clk); #1;
    wen = 1'b1;
    data_in = $urandom;
    for (int i = 0; i < BYTES; i++) begin
      pb = bus;
      n = 0;
      while (wrn && n < 20) begin n++; pb = bus; @(posedge clk); #1; end
      chk("wr_setup_cycles", n, 1);
      chk("wr_setup_bus", pb, {24'h0, w[i*8 +: 8]});
      n = 0;
      while (!wrn && n < 20) begin
        n++;
        chk("wr_strobe_bus", bus, {24'h0, w[i*8 +: 8]});
        @(posedge clk); #1;
      end
      chk("wr_pulse_len", n, WRP);
      repeat ($urandom_range(0, 4)) begin
        chk("wr_tbre_hold", {done, wrn, bus}, {2'b01, 24'h0, w[i*8 +: 8]});
        @(posedge clk); #1;
      end
      tbre = 1'b1;
      repeat ($urandom_range(1, 4)) begin
        chk("wr_tsre_hold", {done, wrn, bus}, {2'b01, 24'h0, w[i*8 +: 8]});
        @(posedge clk); #1;
      end
      tsre = 1'b1;
      @(posedge clk); #1;
      tbre = 1'b0;
      tsre = 1'b0;
    end
    exp_err = 1'b0;
    chk("wr_done", done, 1);
    chk("wr_err", err, 0);
    chk("wr_data_out", data_out, exp_out);
    probe = 1'b1;
    #1;
    chk("wr_bus_hiz", bus, 0);
    @(posedge clk); #1;
    chk("wr_idle", done, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [31:0] w;
    int n, ns;
    oen = 1'b1; wen = 1'b1; dready = 1'b0; tbre = 1'b0; tsre = 1'b0; probe = 1'b1;
    data_in = '0; u_byte = '0; oen1 = 1'b1; dready1 = 1'b0; b1 = '0;
    exp_out = '0; exp_err = 1'b0;
    vt[0] = '{1'b1, 1'b0, 32'hA1B2C3D4, 4, 32'hA1B2C3D4, 1'b0};
    vt[1] = '{1'b0, 1'b0, 32'h11223344, 0, 32'hA1B2C3D4, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h55667788, 1, 32'hA1B2C3D4, 1'b1};
    vt[3] = '{1'b1, 1'b1, 32'h0F1E2D3C, 4, 32'h0F1E2D3C, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h99AABBCC, 0, 32'h0F1E2D3C, 1'b1};
    vt[5] = '{1'b0, 1'b0, 32'hDEADBEEF, 0, 32'h0F1E2D3C, 1'b0};
    repeat (2) @(posedge clk); #1;
    chk("rst_state", {done, err, rdn, wrn, data_out}, {4'b0011, 32'h0});
    chk("rst_bus", bus, 0);
    chk("rst_state1", {done1, err1, rdn1, wrn1, data_out1}, {4'b0011, 8'h0});
    rst = 1'b0;
    @(posedge clk); #1;
    b1 = 8'h5A;
    oen1 = 1'b0;
    dready1 = 1'b1;
    n = 0;
    while (rdn1 && n < 20) begin n++; @(posedge clk); #1; end
    n = 0;
    while (!rdn1 && n < 20) begin n++; @(posedge clk); #1; end
    dready1 = 1'b0;
    chk("d_rd_pulse", n, 1);
    chk("d_data_out", data_out1, 8'h5A);
    chk("d_done", done1, 1);
    repeat (3) begin @(posedge clk); #1; chk("d_done_hold", done1, 1); end
    oen1 = 1'b1;
    @(posedge clk); #1;
    chk("d_done_clr", done1, 0);
    oen1 = 1'b0;
    @(posedge clk); #1;
    oen1 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("d_no_timeout", {done1, err1, rdn1}, 3'b001);
    b1 = 8'hC3;
    dready1 = 1'b1;
    n = 0;
    while (rdn1 && n < 20) begin n++; @(posedge clk); #1; end
    n = 0;
    while (!rdn1 && n < 20) begin n++; @(posedge clk); #1; end
    dready1 = 1'b0;
    chk("d_late_data", {done1, data_out1}, {1'b1, 8'hC3});
    @(posedge clk); #1;
    chk("d_late_idle", done1, 0);
    for (int i = 0; i < 6; i++) begin
      if (vt[i].rd) do_read(vt[i].w, vt[i].ns, vt[i].both);
      else do_write(vt[i].w);
      chk("vec_data_out", data_out, vt[i].exp_out);
      chk("vec_err", err, vt[i].exp_err);
    end
    for (int v = 0; v < 2; v++) begin
      data_in = 32'hCAFEF00D;
      wen = 1'b0;
      probe = 1'b0;
      @(posedge clk); #1;
      wen = 1'b1;
      n = 0;
      while (wrn && n < 20) begin n++; @(posedge clk); #1; end
      n = 0;
      while (!wrn && n < 20) begin n++; @(posedge clk); #1; end
      tbre = v[0];
      n = 0;
      while (!done && n < 40) begin n++; @(posedge clk); #1; end
      tbre = 1'b0;
      chk("wr_timeout_cycles", n, TMO + v);
      chk("wr_timeout_flags", {err, rdn, wrn}, 3'b111);
      probe = 1'b1;
      #1;
      chk("wr_timeout_bus", bus, 0);
      exp_err = 1'b1;
      @(posedge clk); #1;
      chk("wr_timeout_idle", {done, err}, 2'b01);
    end
    data_in = 32'h12345678;
    wen = 1'b0;
    probe = 1'b0;
    @(posedge clk); #1;
    wen = 1'b1;
    n = 0;
    while (wrn && n < 20) begin n++; @(posedge clk); #1; end
    chk("rst_pre_wrn", wrn, 0);
    rst = 1'b1;
    probe = 1'b1;
    #1;
    chk("rst_mid_strobe", {wrn, rdn, done, err, data_out}, {4'b1100, 32'h0});
    chk("rst_mid_bus", bus, 0);
    exp_out = '0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(32'h9ABCDEF0, BYTES, 1'b0);
    for (int i = 0; i < 24; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ns = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BYTES - 1)) : BYTES;
        do_read(w, ns, $urandom_range(0, 3) == 0);
      end else do_write(w);
      chk("rand_data_out", data_out, exp_out);
      chk("rand_err", err, exp_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
